// File: rtl/alu_pkg.sv
// Shared encodings and state type for the two-port ALU scheduler.
// Flag bit positions describe the {N,Z,C,V} layout of alu_flags/rsp_flags/flags_q.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_MOV = 3'b101;
    localparam logic [2:0] OP_BNE = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_t;

    function automatic logic is_illegal(input logic [2:0] sel);
        return sel == OP_ILL;
    endfunction

endpackage

// File: rtl/alu_sched_rr_arb2.sv
// Two-way round-robin grant: with both requesters valid, the one that did not
// win last time is chosen; a lone valid requester always wins.
module rr_arb2 (
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_rr_last,
    output logic o_gnt_any,
    output logic o_gnt_id
);

    always_comb begin
        o_gnt_any = i_valid0 | i_valid1;
        if (i_valid0 && i_valid1) begin
            o_gnt_id = ~i_rr_last;
        end else begin
            o_gnt_id = i_valid1;
        end
    end

endmodule

// File: rtl/alu_sched.sv
// Shares one external combinational ALU between two issue ports: round-robin
// accept, registered operand stage, registered response stage, NZCV register.
module alu_sched
    import alu_pkg::*;
#(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [N-1:0]   req0_a,
    input  logic [N-1:0]   req0_b,
    input  logic [2:0]     req0_sel,
    input  logic           req0_setf,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [N-1:0]   req1_a,
    input  logic [N-1:0]   req1_b,
    input  logic [2:0]     req1_sel,
    input  logic           req1_setf,
    output logic [N-1:0]   alu_a,
    output logic [N-1:0]   alu_b,
    output logic [2:0]     alu_sel,
    input  logic [2*N-1:0] alu_result,
    input  logic [3:0]     alu_flags,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [2*N-1:0] rsp_result,
    output logic [3:0]     rsp_flags,
    output logic           rsp_err,
    output logic [3:0]     flags_q,
    output logic [1:0]     dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; requesters hold operands while valid&!ready, consumer likewise.
    sched_state_t   r_state;
    logic           r_rr_last;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [2:0]     r_sel;
    logic           r_setf;
    logic           r_id;
    logic           r_rsp_valid;
    logic           r_rsp_id;
    logic [2*N-1:0] r_rsp_result;
    logic [3:0]     r_rsp_flags;
    logic           r_rsp_err;
    logic [3:0]     r_flags_q;

    logic w_can_accept;
    logic w_gnt_any;
    logic w_gnt_id;
    logic w_accept;

    rr_arb2 u_arb (
        .i_valid0  (req0_valid),
        .i_valid1  (req1_valid),
        .i_rr_last (r_rr_last),
        .o_gnt_any (w_gnt_any),
        .o_gnt_id  (w_gnt_id)
    );

    assign w_can_accept = (r_state == IDLE) || ((r_state == RESP) && rsp_ready);
    assign w_accept     = w_can_accept && w_gnt_any;
    assign req0_ready   = w_accept && !w_gnt_id;
    assign req1_ready   = w_accept && w_gnt_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_rr_last    <= 1'b1;
            r_a          <= '0;
            r_b          <= '0;
            r_sel        <= '0;
            r_setf       <= 1'b0;
            r_id         <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_rsp_err    <= 1'b0;
            r_flags_q    <= '0;
        end else begin
            // Accept is only possible in IDLE, or in RESP while the old response leaves.
            if (w_accept) begin
                r_a       <= w_gnt_id ? req1_a    : req0_a;
                r_b       <= w_gnt_id ? req1_b    : req0_b;
                r_sel     <= w_gnt_id ? req1_sel  : req0_sel;
                r_setf    <= w_gnt_id ? req1_setf : req0_setf;
                r_id      <= w_gnt_id;
                r_rr_last <= w_gnt_id;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) r_state <= EXEC;
                end
                EXEC: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_id    <= r_id;
                    if (is_illegal(r_sel)) begin
                        r_rsp_result <= '0;
                        r_rsp_flags  <= '0;
                        r_rsp_err    <= 1'b1;
                    end else begin
                        r_rsp_result <= alu_result;
                        r_rsp_flags  <= alu_flags;
                        r_rsp_err    <= 1'b0;
                        if (r_setf) r_flags_q <= alu_flags;
                    end
                    r_state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= w_accept ? EXEC : IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_sel    = r_sel;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign rsp_err    = r_rsp_err;
    assign flags_q    = r_flags_q;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched: a small ALU model on the alu_* side, a vector
// table of single operations, and hand sequences for contention, stall, reset.
module tb_alu_sched;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready, req0_setf;
    logic [15:0] req0_a, req0_b;
    logic [2:0]  req0_sel;
    logic        req1_valid, req1_ready, req1_setf;
    logic [15:0] req1_a, req1_b;
    logic [2:0]  req1_sel;
    logic [15:0] alu_a, alu_b;
    logic [2:0]  alu_sel;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags, flags_q;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    alu_sched #(.N(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_sel(req0_sel), .req0_setf(req0_setf),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_sel(req1_sel), .req1_setf(req1_setf),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .flags_q(flags_q), .dbg_state(dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: flags {N,Z,C,V}; illegal op returns junk the block must discard
    logic [16:0] s17;
    always_comb begin
        s17        = '0;
        alu_result = '0;
        alu_flags  = '0;
        case (alu_sel)
            3'b000: begin
                s17 = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = {16'h0, s17[15:0]};
                alu_flags = {s17[15], s17[15:0] == 16'h0, s17[16],
                             (alu_a[15] == alu_b[15]) && (s17[15] != alu_a[15])};
            end
            3'b001: begin
                s17 = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
                alu_result = {16'h0, s17[15:0]};
                alu_flags = {s17[15], s17[15:0] == 16'h0, s17[16],
                             (alu_a[15] != alu_b[15]) && (s17[15] != alu_a[15])};
            end
            3'b010: alu_result = {16'h0, alu_a & alu_b};
            3'b011: alu_result = {16'h0, alu_a | alu_b};
            3'b100: alu_result = {16'h0, alu_a} * {16'h0, alu_b};
            3'b101: alu_result = {16'h0, alu_a};
            3'b110: alu_result = {31'h0, alu_a != alu_b};
            default: alu_result = 32'hDEAD_BEEF;
        endcase
        if (alu_sel == 3'b111) begin
            alu_flags = 4'hF;
        end else if (alu_sel != 3'b000 && alu_sel != 3'b001) begin
            alu_flags = {alu_result[31] | (alu_sel != 3'b100 && alu_result[15]),
                         alu_result == 32'h0, 2'b00};
        end
    end

    typedef struct {
        logic        id;
        logic [2:0]  sel;
        logic [15:0] a;
        logic [15:0] b;
        logic        setf;
        logic [31:0] res;
        logic [3:0]  flg;
        logic        err;
        logic [3:0]  fq;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic drive_req(input logic id, input logic [2:0] sel, input logic [15:0] a,
                             input logic [15:0] b, input logic setf);
        if (id) begin
            req1_valid = 1'b1; req1_sel = sel; req1_a = a; req1_b = b; req1_setf = setf;
        end else begin
            req0_valid = 1'b1; req0_sel = sel; req0_a = a; req0_b = b; req0_setf = setf;
        end
    endtask

    task automatic clear_reqs();
        req0_valid = 1'b0; req0_sel = 3'b000; req0_a = '0; req0_b = '0; req0_setf = 1'b0;
        req1_valid = 1'b0; req1_sel = 3'b000; req1_a = '0; req1_b = '0; req1_setf = 1'b0;
    endtask

    // Issue one op, wait (bounded) for accept, then check the 2-cycle latency.
    task automatic issue(input vec_t v, input string tag);
        int n;
        drive_req(v.id, v.sel, v.a, v.b, v.setf);
        #1;
        n = 0;
        while (!(v.id ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_accept"}, 32'(v.id ? req1_ready : req0_ready), 32'd1);
        @(negedge clk);
        clear_reqs();
        chk({tag, "_exec_no_rsp"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        vec_t v;
        rst = 1'b1;
        rsp_ready = 1'b1;
        clear_reqs();

        vecs[0] = '{1'b0, 3'b000, 16'h7FFF, 16'h0001, 1'b1, 32'h0000_8000, 4'b1001, 1'b0, 4'b1001};
        vecs[1] = '{1'b1, 3'b100, 16'h0100, 16'h0100, 1'b0, 32'h0001_0000, 4'b0000, 1'b0, 4'b1001};
        vecs[2] = '{1'b0, 3'b010, 16'hF0F0, 16'hFF00, 1'b1, 32'h0000_F000, 4'b1000, 1'b0, 4'b1000};
        vecs[3] = '{1'b1, 3'b111, 16'hFFFF, 16'h0001, 1'b1, 32'h0000_0000, 4'b0000, 1'b1, 4'b1000};
        vecs[4] = '{1'b0, 3'b000, 16'hFFFF, 16'h0001, 1'b1, 32'h0000_0000, 4'b0110, 1'b0, 4'b0110};
        vecs[5] = '{1'b1, 3'b101, 16'h1234, 16'h5555, 1'b0, 32'h0000_1234, 4'b0000, 1'b0, 4'b0110};
        vecs[6] = '{1'b0, 3'b110, 16'h0005, 16'h0005, 1'b1, 32'h0000_0000, 4'b0100, 1'b0, 4'b0100};
        vecs[7] = '{1'b1, 3'b111, 16'h00AA, 16'h0055, 1'b0, 32'h0000_0000, 4'b0000, 1'b1, 4'b0100};
        vecs[8] = '{1'b1, 3'b001, 16'h0003, 16'h0005, 1'b0, 32'h0000_FFFE, 4'b1000, 1'b0, 4'b0100};

        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_flags_q", 32'(flags_q), 32'd0);
        chk("reset_alu_a", 32'(alu_a), 32'd0);
        chk("reset_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_rsp_result", rsp_result, 32'd0);
        chk("idle_req0_ready", 32'(req0_ready), 32'd0);

        // Contention right after reset: req0 first, then strict alternation.
        drive_req(1'b0, 3'b001, 16'h0005, 16'h0005, 1'b1);
        drive_req(1'b1, 3'b011, 16'h00F0, 16'h0F00, 1'b0);
        #1;
        chk("cont_req0_ready", 32'(req0_ready), 32'd1);
        chk("cont_req1_ready", 32'(req1_ready), 32'd0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk($sformatf("cont%0d_exec", k), 32'(rsp_valid), 32'd0);
            @(negedge clk);
            chk($sformatf("cont%0d_valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("cont%0d_id", k), 32'(rsp_id), 32'(k % 2));
            chk($sformatf("cont%0d_result", k), rsp_result,
                (k % 2 == 0) ? 32'h0000_0000 : 32'h0000_0FF0);
            chk($sformatf("cont%0d_flags", k), 32'(rsp_flags),
                (k % 2 == 0) ? 32'h6 : 32'h0);
        end
        clear_reqs();
        chk("cont_flags_q", 32'(flags_q), 32'h6);
        @(negedge clk);

        // Vector table
        for (int i = 0; i < 9; i++) begin
            issue(vecs[i], $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_id", i), 32'(rsp_id), 32'(vecs[i].id));
            chk($sformatf("vec%0d_result", i), rsp_result, vecs[i].res);
            chk($sformatf("vec%0d_flags", i), 32'(rsp_flags), 32'(vecs[i].flg));
            chk($sformatf("vec%0d_err", i), 32'(rsp_err), 32'(vecs[i].err));
            chk($sformatf("vec%0d_flags_q", i), 32'(flags_q), 32'(vecs[i].fq));
            @(negedge clk);
            chk($sformatf("vec%0d_drained", i), 32'(rsp_valid), 32'd0);
        end

        // Backpressure: response held with req0 pending, released mid-cycle
        rsp_ready = 1'b0;
        v = '{1'b0, 3'b000, 16'h0001, 16'h0002, 1'b0, 32'h3, 4'h0, 1'b0, 4'h4};
        issue(v, "bp_first");
        drive_req(1'b0, 3'b011, 16'h000F, 16'h00F0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp%0d_valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp%0d_result", k), rsp_result, 32'h3);
            chk($sformatf("bp%0d_req0_ready", k), 32'(req0_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_req0_ready", 32'(req0_ready), 32'd1);
        @(negedge clk);
        clear_reqs();
        chk("bp_exec", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("bp_next_valid", 32'(rsp_valid), 32'd1);
        chk("bp_next_result", rsp_result, 32'h0000_00FF);
        @(negedge clk);

        // Async reset while an op is in EXEC
        issue(vecs[0], "pre_rst");
        chk("pre_rst_flags_q", 32'(flags_q), 32'h9);
        @(negedge clk);
        drive_req(1'b0, 3'b101, 16'h4321, 16'h0000, 1'b1);
        #1;
        chk("rst_op_accept", 32'(req0_ready), 32'd1);
        @(negedge clk);
        clear_reqs();
        chk("rst_op_in_exec", 32'(dbg_state), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_state", 32'(dbg_state), 32'd0);
        chk("rst_flags_q", 32'(flags_q), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_sel", 32'(alu_sel), 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d_valid", k), 32'(rsp_valid), 32'd0);
        end
        drive_req(1'b0, 3'b000, 16'h0001, 16'h0001, 1'b0);
        drive_req(1'b1, 3'b000, 16'h0002, 16'h0002, 1'b0);
        #1;
        chk("post_rst_req0_wins", 32'(req0_ready), 32'd1);
        chk("post_rst_req1_waits", 32'(req1_ready), 32'd0);
        clear_reqs();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
